// File: rtl/hazard_scoreboard.sv
// Decode-stage pending-write scoreboard: per-register forwarding countdown plus optional variable-latency flag.
// Optional feature macro SB_VARLAT_EN adds write-back-cleared variable-latency tracking.
module hazard_scoreboard #(
  parameter int LAT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             issue_valid,
  input  logic [4:0]       issue_rd,
  input  logic [LAT_W-1:0] issue_lat,
  input  logic [4:0]       de_rs,
  input  logic             de_rs_en,
  input  logic [4:0]       de_rt,
  input  logic             de_rt_en,
  input  logic             wb_valid,
  input  logic [4:0]       wb_rd,
  output logic             rs_pending,
  output logic             rt_pending,
  output logic             stall
);

  logic [LAT_W-1:0] cnt [1:31];
  logic [31:0]      busy;
  logic             issue_take;

`ifdef SB_VARLAT_EN
  logic [31:1] var_pend;
`else
  logic unused_wb;
  assign unused_wb = ^{wb_valid, wb_rd};
`endif

  always_comb begin
    busy = '0;
    for (int r = 1; r < 32; r++) begin
`ifdef SB_VARLAT_EN
      busy[r] = (cnt[r] != '0) | var_pend[r];
`else
      busy[r] = (cnt[r] != '0);
`endif
    end
  end

  assign rs_pending = de_rs_en & busy[de_rs];
  assign rt_pending = de_rt_en & busy[de_rt];
  assign stall      = rs_pending | rt_pending;

  // A squashed issue must not load anything, so flush gates acceptance.
  assign issue_take = issue_valid & ~stall & ~flush & (issue_rd != 5'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 1; r < 32; r++) cnt[r] <= '0;
    end else begin
      for (int r = 1; r < 32; r++) begin
        if (flush)
          cnt[r] <= '0;
        else if (issue_take && issue_rd == 5'(r))
          cnt[r] <= issue_lat;
        else if (cnt[r] != '0)
          cnt[r] <= cnt[r] - LAT_W'(1);
      end
    end
  end

`ifdef SB_VARLAT_EN
  // Flush leaves these alone: dispatched long ops still retire through write-back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      var_pend <= '0;
    end else begin
      for (int r = 1; r < 32; r++) begin
        if (issue_take && issue_rd == 5'(r))
          var_pend[r] <= (issue_lat == '0);
        else if (wb_valid && wb_rd == 5'(r))
          var_pend[r] <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed self-checking bench for hazard_scoreboard; inputs driven and outputs checked at the falling edge.
module tb_hazard_scoreboard;
  localparam int LAT_W = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush;
  logic             issue_valid;
  logic [4:0]       issue_rd;
  logic [LAT_W-1:0] issue_lat;
  logic [4:0]       de_rs;
  logic             de_rs_en;
  logic [4:0]       de_rt;
  logic             de_rt_en;
  logic             wb_valid;
  logic [4:0]       wb_rd;
  logic             rs_pending;
  logic             rt_pending;
  logic             stall;

  int pass_cnt = 0;
  int total    = 0;

  always #5 clk = ~clk;

  hazard_scoreboard #(.LAT_W(LAT_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_lat(issue_lat),
    .de_rs(de_rs), .de_rs_en(de_rs_en), .de_rt(de_rt), .de_rt_en(de_rt_en),
    .wb_valid(wb_valid), .wb_rd(wb_rd),
    .rs_pending(rs_pending), .rt_pending(rt_pending), .stall(stall)
  );

  task automatic idle();
    flush = 0; issue_valid = 0; issue_rd = 0; issue_lat = 0;
    wb_valid = 0; wb_rd = 0; de_rs_en = 0; de_rt_en = 0; de_rs = 0; de_rt = 0;
  endtask

  // Move to the falling edge of the next cycle with all inputs idle.
  task automatic next_cycle();
    @(negedge clk);
    idle();
  endtask

  task automatic issue(input logic [4:0] rd, input logic [LAT_W-1:0] lat);
    issue_valid = 1; issue_rd = rd; issue_lat = lat;
  endtask

  task automatic drain();
    for (int i = 0; i < 10; i++) next_cycle();
  endtask

  task automatic test_reset();
    idle();
    rst_n = 0;
    #1;
    total++;
    if (stall !== 1'b0) $display("FAIL reset_stall got %b exp 0", stall);
    else pass_cnt++;
    @(negedge clk); rst_n = 1;
    next_cycle();
    de_rs = 5; de_rs_en = 1; de_rt = 31; de_rt_en = 1; #1;
    total++;
    if ({rs_pending, rt_pending} !== 2'b00) $display("FAIL reset_pending got %b exp 00", {rs_pending, rt_pending});
    else pass_cnt++;
  endtask

  task automatic test_load_use();
    next_cycle(); issue(5, 1);
    next_cycle(); de_rs = 5; de_rs_en = 1; #1;
    total++;
    if (stall !== 1'b1) $display("FAIL load_use_t1 got %b exp 1", stall);
    else pass_cnt++;
    next_cycle(); de_rs = 5; de_rs_en = 1; #1;
    total++;
    if (stall !== 1'b0) $display("FAIL load_use_t2 got %b exp 0", stall);
    else pass_cnt++;
    drain();
  endtask

  task automatic test_counter();
    logic exp_s [0:3];
    exp_s = '{1'b1, 1'b1, 1'b1, 1'b0};
    next_cycle(); issue(7, 3);
    for (int i = 0; i < 4; i++) begin
      next_cycle(); de_rt = 7; de_rt_en = 1; #1;
      total++;
      if (stall !== exp_s[i]) $display("FAIL lat3_cycle%0d got %b exp %b", i + 1, stall, exp_s[i]);
      else pass_cnt++;
    end
    drain();
    // Enable gating: same busy register, source not read.
    next_cycle(); issue(7, 3);
    next_cycle(); de_rt = 7; de_rt_en = 0; #1;
    total++;
    if ({rt_pending, stall} !== 2'b00) $display("FAIL rt_en_off got %b exp 00", {rt_pending, stall});
    else pass_cnt++;
    next_cycle(); de_rt = 7; de_rt_en = 1; #1;
    total++;
    if (rt_pending !== 1'b1) $display("FAIL rt_en_on got %b exp 1", rt_pending);
    else pass_cnt++;
    drain();
    next_cycle(); issue(0, 3);
    for (int i = 0; i < 3; i++) begin
      next_cycle(); de_rs = 0; de_rs_en = 1; de_rt = 0; de_rt_en = 1; #1;
      total++;
      if (stall !== 1'b0) $display("FAIL r0_cycle%0d got %b exp 0", i + 1, stall);
      else pass_cnt++;
    end
    drain();
  endtask

  task automatic test_stall_gating();
    next_cycle(); issue(7, 3);
    next_cycle(); de_rt = 7; de_rt_en = 1; issue(8, 2); #1;
    total++;
    if (stall !== 1'b1) $display("FAIL gate_stall got %b exp 1", stall);
    else pass_cnt++;
    next_cycle(); de_rs = 8; de_rs_en = 1; #1;
    total++;
    if (rs_pending !== 1'b0) $display("FAIL gate_not_loaded got %b exp 0", rs_pending);
    else pass_cnt++;
    drain();
  endtask

  task automatic test_waw();
    next_cycle(); issue(3, 4);
    next_cycle();
    next_cycle(); issue(3, 1);
    next_cycle(); de_rs = 3; de_rs_en = 1; #1;
    total++;
    if (rs_pending !== 1'b1) $display("FAIL waw_busy got %b exp 1", rs_pending);
    else pass_cnt++;
    next_cycle(); de_rs = 3; de_rs_en = 1; #1;
    total++;
    if (rs_pending !== 1'b0) $display("FAIL waw_clear got %b exp 0", rs_pending);
    else pass_cnt++;
    drain();
  endtask

  task automatic test_variable();
`ifdef SB_VARLAT_EN
    int bad;
    next_cycle(); issue(9, 0);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      next_cycle(); de_rs = 9; de_rs_en = 1; #1;
      total++;
      if (stall !== 1'b1) begin
        $display("FAIL var_hold_cycle%0d got %b exp 1", i + 1, stall);
        bad++;
      end else pass_cnt++;
    end
    next_cycle(); wb_valid = 1; wb_rd = 9; de_rs = 9; de_rs_en = 1; #1;
    total++;
    if (stall !== 1'b1) $display("FAIL var_wb_cycle got %b exp 1", stall);
    else pass_cnt++;
    next_cycle(); de_rs = 9; de_rs_en = 1; #1;
    total++;
    if (stall !== 1'b0) $display("FAIL var_after_wb got %b exp 0", stall);
    else pass_cnt++;
    // Write-back and a new fixed issue to r9 together: issue wins.
    next_cycle(); issue(9, 0);
    next_cycle(); wb_valid = 1; wb_rd = 9; issue(9, 2);
    for (int i = 0; i < 3; i++) begin
      next_cycle(); de_rs = 9; de_rs_en = 1; #1;
      total++;
      if (rs_pending !== (i < 2)) $display("FAIL wb_issue_cycle%0d got %b exp %b", i + 1, rs_pending, (i < 2));
      else pass_cnt++;
    end
`else
    next_cycle(); issue(9, 0);
    next_cycle(); de_rs = 9; de_rs_en = 1; #1;
    total++;
    if (stall !== 1'b0) $display("FAIL lat0_no_hazard got %b exp 0", stall);
    else pass_cnt++;
    next_cycle(); issue(9, 2);
    next_cycle(); wb_valid = 1; wb_rd = 9; de_rs = 9; de_rs_en = 1; #1;
    total++;
    if (stall !== 1'b1) $display("FAIL wb_ignored got %b exp 1", stall);
    else pass_cnt++;
`endif
    drain();
  endtask

  task automatic test_flush();
    next_cycle(); issue(4, 5);
    next_cycle(); issue(9, 0);
    next_cycle(); de_rs = 4; de_rs_en = 1; #1;
    total++;
    if (rs_pending !== 1'b1) $display("FAIL pre_flush_r4 got %b exp 1", rs_pending);
    else pass_cnt++;
    next_cycle(); flush = 1; issue(6, 3);
    next_cycle(); de_rs = 4; de_rs_en = 1; de_rt = 6; de_rt_en = 1; #1;
    total++;
    if ({rs_pending, rt_pending} !== 2'b00) $display("FAIL flush_r4_r6 got %b exp 00", {rs_pending, rt_pending});
    else pass_cnt++;
`ifdef SB_VARLAT_EN
    de_rs = 9; #1;
    total++;
    if (rs_pending !== 1'b1) $display("FAIL flush_keeps_var got %b exp 1", rs_pending);
    else pass_cnt++;
    next_cycle(); wb_valid = 1; wb_rd = 9;
`endif
    drain();
  endtask

  task automatic test_reset_mid();
    next_cycle(); issue(5, 7);
    next_cycle(); issue(9, 0);
    next_cycle(); de_rs = 5; de_rs_en = 1; #1;
    total++;
    if (stall !== 1'b1) $display("FAIL pre_reset_busy got %b exp 1", stall);
    else pass_cnt++;
    rst_n = 0; #1;
    total++;
    if (stall !== 1'b0) $display("FAIL reset_mid_stall got %b exp 0", stall);
    else pass_cnt++;
    next_cycle(); rst_n = 1;
    next_cycle(); de_rs = 5; de_rs_en = 1; de_rt = 9; de_rt_en = 1; #1;
    total++;
    if ({rs_pending, rt_pending} !== 2'b00) $display("FAIL reset_mid_after got %b exp 00", {rs_pending, rt_pending});
    else pass_cnt++;
  endtask

  initial begin
    idle();
    rst_n = 1;
    test_reset();
    test_load_use();
    test_counter();
    test_stall_gating();
    test_waw();
    test_variable();
    test_flush();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Per-register pending-write tracker that sits in the decode stage, on the producer side of the operand bypass network. It records every issued destination register together with the number of cycles before that result reaches a forwardable pipeline stage. It then stalls decode while a source operand's producer is still in flight and cannot yet be bypassed. It covers fixed-latency producers such as load-use and multiply, and variable-latency producers such as divide and cache miss, which complete through write-back.

## Interface
Parameters:
- LAT_W, 3, width of the per-register latency countdown; maximum fixed latency is 2^LAT_W-1.

Ports (clock and reset first):
- clk  input  1  core clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- flush  input  1  pipeline squash; clears fixed-latency entries.
- issue_valid  input  1  decode presents an instruction with a destination.
- issue_rd  input  5  destination register of the issuing instruction.
- issue_lat  input  LAT_W  number of cycles until the result is forwardable; 0 means variable latency, cleared by write-back.
- de_rs  input  5  first source register in decode.
- de_rs_en  input  1  first source is actually read.
- de_rt  input  5  second source register in decode.
- de_rt_en  input  1  second source is actually read.
- wb_valid  input  1  a variable-latency producer is writing back.
- wb_rd  input  5  register written by that producer.
- rs_pending  output  1  de_rs is busy and de_rs_en=1.
- rt_pending  output  1  de_rt is busy and de_rt_en=1.
- stall  output  1  rs_pending | rt_pending; holds decode and blocks issue.

## Operation
- State per register r in 1..31:
  - cnt[r], LAT_W bits.
  - var[r], 1 bit.
  - busy[r] = (cnt[r]!=0) | var[r].
- Register 0 is never tracked; busy[0]=0 always.
- Issue is accepted when issue_valid & !stall & issue_rd!=0.
  - issue_lat!=0: cnt[rd] <= issue_lat and var[rd] <= 0.
  - issue_lat==0: var[rd] <= 1 and cnt[rd] <= 0.
  - Any issue overwrites a prior entry for the same rd (WAW: the newest producer wins).
- Every edge, every cnt[r]!=0 that is not being loaded decrements by 1. The counter never wraps below 0.
- wb_valid & wb_rd!=0 clears var[wb_rd].
- Write-back and an accepted issue to the same register in the same cycle: the issue wins, and the entry holds the new producer.
- flush clears all cnt[]. It leaves var[] intact, because long ops already dispatched still retire through write-back.
- flush together with an accepted issue in the same cycle: the flush wins and nothing is loaded. A variable issue is also dropped.
- rs_pending, rt_pending and stall are combinational from registered state and current decode inputs. There is no dependence on issue_valid, so there is no combinational loop.

## Timing
- Reset, asynchronous: all cnt=0 and var=0. stall, rs_pending and rt_pending read 0 immediately.
- A fixed issue accepted at the edge ending cycle T with issue_lat=L makes busy visible in cycles T+1..T+L. It reads not-busy from T+L+1, with zero extra latency after that.
  - L=1 gives a single load-use bubble.
- Variable issue: busy from T+1 until the cycle after the edge that samples the matching wb_valid.
- flush asserted in cycle F: fixed entries read not-busy from F+1.
- Reset asserted mid-operation discards all entries. No pending write-back is remembered afterwards.

## Configuration
- SB_VARLAT_EN defined: var[] storage is present, and wb_valid/wb_rd are used. issue_lat==0 behaves as variable latency.
- SB_VARLAT_EN undefined: var[] is removed and wb_valid/wb_rd are ignored. issue_lat==0 means no hazard, and the entry is left not-busy, which is a plain overwrite with cnt=0.

## Test plan
- Reset values: reset mid-stream while entries are busy → stall=0 immediately. With rs=5, rs_en=1 after release → rs_pending=0.
- Load-use: issue rd=5, lat=1 at T; decode rs=5, rs_en=1 → stall=1 only in T+1, 0 in T+2.
- Counter and enables: issue rd=7, lat=3 → stall on rt=7 for exactly 3 cycles. With de_rt_en=0 → no stall. rd=0, lat=3 → never busy.
- Variable (SB_VARLAT_EN): issue rd=9, lat=0; hold 20 cycles → stall=1 throughout.
  - wb_valid, wb_rd=9 → stall=0 next cycle.
  - Same-cycle wb_rd=9 with an accepted issue rd=9, lat=2 → busy for 2 cycles.
- Flush: with rd=4 lat=5 and rd=9 var pending, assert flush → r4 not-busy next cycle, r9 still busy.
  - flush with a simultaneous issue rd=6 → r6 not-busy.
- WAW and stall gating:
  - issue rd=3 lat=4, then rd=3 lat=1 two cycles later → r3 clears after 1 cycle.
  - issue_valid while stall=1 → entry not loaded.
